// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared processor package: decode-control bundle layout and register-index width.
package id_ex_pipe_reg_pkg;

  localparam int unsigned XLEN      = 16;
  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned CTRL_W    = 16;
  localparam int unsigned CNT_W     = 16;

  // Bit offsets of the ctrl bundle fields, MSB first, for controller-side packing.
  localparam int unsigned CTRL_REGWRITE_BIT   = 15;
  localparam int unsigned CTRL_MEMTOREG_BIT   = 14;
  localparam int unsigned CTRL_MEMREAD_BIT    = 13;
  localparam int unsigned CTRL_MEMWRITE_BIT   = 12;
  localparam int unsigned CTRL_BRANCH_BIT     = 11;
  localparam int unsigned CTRL_REGDEST_BIT    = 10;
  localparam int unsigned CTRL_PC_REGREAD_BIT = 9;
  localparam int unsigned CTRL_LHI_REG_BIT    = 8;
  localparam int unsigned CTRL_ALUSRC_LSB     = 6;
  localparam int unsigned CTRL_IRLAST_LSB     = 4;
  localparam int unsigned CTRL_ALUOP_LSB      = 0;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       regdest;
    logic       pc_regread;
    logic       lhi_reg;
    logic [1:0] alusrc;
    logic [1:0] irlast;
    logic [3:0] aluop;
  } ctrl_t;

  localparam logic [CNT_W-1:0] BUBBLE_CNT_MAX = CNT_W'(16'hFFFF);

endpackage

// File: rtl/id_ex_pipe_reg_lu_hazard_detect.sv
// Load-use hazard compare between the ID instruction and the load sitting in EX.
module lu_hazard_detect
  import id_ex_pipe_reg_pkg::*;
(
  input  logic                 valid_id_i,
  input  logic                 valid_ex_i,
  input  logic                 memread_ex_i,
  input  logic                 regwrite_ex_i,
  input  logic                 use_a_i,
  input  logic                 use_b_i,
  input  logic [REG_IDX_W-1:0] src_a_i,
  input  logic [REG_IDX_W-1:0] src_b_i,
  input  logic [REG_IDX_W-1:0] dst_ex_i,
  output logic                 load_use_c_o
);

  logic hit_a;
  logic hit_b;

  assign hit_a        = use_a_i & (src_a_i == dst_ex_i);
  assign hit_b        = use_b_i & (src_b_i == dst_ex_i);
  assign load_use_c_o = valid_id_i & valid_ex_i & memread_ex_i & regwrite_ex_i & (hit_a | hit_b);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush/hold control
// and a saturating count of inserted bubbles.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  ctrl_t                ctrl_id,
  input  logic                 valid_id,
  input  logic [XLEN-1:0]      pc_id,
  input  logic [XLEN-1:0]      ir_id,
  input  logic [XLEN-1:0]      rd1_id,
  input  logic [XLEN-1:0]      rd2_id,
  input  logic [REG_IDX_W-1:0] src_a_id,
  input  logic [REG_IDX_W-1:0] src_b_id,
  input  logic                 use_a_id,
  input  logic                 use_b_id,
  input  logic [REG_IDX_W-1:0] dst_id,
  input  logic                 flush_ex,
  input  logic                 hold_ex,
  output ctrl_t                ctrl_ex,
  output logic [XLEN-1:0]      pc_ex,
  output logic [XLEN-1:0]      ir_ex,
  output logic [XLEN-1:0]      rd1_ex,
  output logic [XLEN-1:0]      rd2_ex,
  output logic [REG_IDX_W-1:0] dst_ex,
  output logic                 valid_ex,
  output logic                 stall_id,
  output logic [CNT_W-1:0]     bubble_cnt
);

  ctrl_t                ctrl_q,   ctrl_d;
  logic [XLEN-1:0]      pc_q,     pc_d;
  logic [XLEN-1:0]      ir_q,     ir_d;
  logic [XLEN-1:0]      rd1_q,    rd1_d;
  logic [XLEN-1:0]      rd2_q,    rd2_d;
  logic [REG_IDX_W-1:0] dst_q,    dst_d;
  logic                 valid_q,  valid_d;
  logic [CNT_W-1:0]     bubble_cnt_q, bubble_cnt_d;
  logic                 load_use;

  lu_hazard_detect u_lu_hazard_detect (
    .valid_id_i    (valid_id),
    .valid_ex_i    (valid_q),
    .memread_ex_i  (ctrl_q.memread),
    .regwrite_ex_i (ctrl_q.regwrite),
    .use_a_i       (use_a_id),
    .use_b_i       (use_b_id),
    .src_a_i       (src_a_id),
    .src_b_i       (src_b_id),
    .dst_ex_i      (dst_q),
    .load_use_c_o  (load_use)
  );

  // A taken flush kills the ID instruction anyway, so it never needs to stall.
  assign stall_id = (load_use | hold_ex) & ~flush_ex;

  // Priority: flush > hold > load-use bubble > normal capture.
  always_comb begin
    ctrl_d       = ctrl_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    rd1_d        = rd1_q;
    rd2_d        = rd2_q;
    dst_d        = dst_q;
    valid_d      = valid_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush_ex) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (hold_ex) begin
      valid_d = valid_q;
    end else if (load_use) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (bubble_cnt_q != BUBBLE_CNT_MAX) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end else begin
      valid_d = valid_id;
      ctrl_d  = valid_id ? ctrl_id : '0;
      pc_d    = pc_id;
      ir_d    = ir_id;
      rd1_d   = rd1_id;
      rd2_d   = rd2_id;
      dst_d   = dst_id;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q       <= '0;
      pc_q         <= '0;
      ir_q         <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      dst_q        <= '0;
      valid_q      <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      dst_q        <= dst_d;
      valid_q      <= valid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ctrl_ex    = ctrl_q;
  assign pc_ex      = pc_q;
  assign ir_ex      = ir_q;
  assign rd1_ex     = rd1_q;
  assign rd2_ex     = rd2_q;
  assign dst_ex     = dst_q;
  assign valid_ex   = valid_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed vector table, corner sequences
// and randomized traffic against a behavioural pipeline-slot model.
module tb_id_ex_pipe_reg;
  import id_ex_pipe_reg_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  ctrl_t       ctrl_id;
  logic        valid_id;
  logic [15:0] pc_id, ir_id, rd1_id, rd2_id;
  logic [2:0]  src_a_id, src_b_id, dst_id;
  logic        use_a_id, use_b_id;
  logic        flush_ex, hold_ex;
  ctrl_t       ctrl_ex;
  logic [15:0] pc_ex, ir_ex, rd1_ex, rd2_ex;
  logic [2:0]  dst_ex;
  logic        valid_ex, stall_id;
  logic [15:0] bubble_cnt;

  id_ex_pipe_reg dut (
    .clk(clk), .reset_n(reset_n), .ctrl_id(ctrl_id), .valid_id(valid_id),
    .pc_id(pc_id), .ir_id(ir_id), .rd1_id(rd1_id), .rd2_id(rd2_id),
    .src_a_id(src_a_id), .src_b_id(src_b_id), .use_a_id(use_a_id), .use_b_id(use_b_id),
    .dst_id(dst_id), .flush_ex(flush_ex), .hold_ex(hold_ex),
    .ctrl_ex(ctrl_ex), .pc_ex(pc_ex), .ir_ex(ir_ex), .rd1_ex(rd1_ex), .rd2_ex(rd2_ex),
    .dst_ex(dst_ex), .valid_ex(valid_ex), .stall_id(stall_id), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    ctrl_t       ctrl;
    logic [15:0] pc, ir, rd1, rd2;
    logic [2:0]  src_a, src_b, dst;
    logic        use_a, use_b, flush, hold;
  } in_t;

  // The EX slot as the architecture sees it.
  typedef struct packed {
    logic        valid;
    ctrl_t       ctrl;
    logic [15:0] pc, ir, rd1, rd2;
    logic [2:0]  dst;
    logic [15:0] bubbles;
  } slot_t;

  typedef struct packed {
    in_t         in;
    logic        exp_stall;
    logic        exp_valid;
    ctrl_t       exp_ctrl;
    logic [15:0] exp_pc;
    logic [15:0] exp_bcnt;
  } vec_t;

  localparam logic [15:0] LW  = 16'hE040;
  localparam logic [15:0] ADD = 16'h8401;
  localparam logic [15:0] ADI = 16'h8041;

  int    errors = 0;
  int    checks = 0;
  slot_t model;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic in_t mk(input logic v, input logic [15:0] c, input logic [15:0] pc,
                             input logic [2:0] dst, input logic [2:0] sa, input logic ua,
                             input logic [2:0] sb, input logic ub, input logic fl, input logic hd);
    in_t r;
    r.valid = v; r.ctrl = ctrl_t'(c); r.pc = pc;
    r.ir = pc ^ 16'hA5A5; r.rd1 = pc + 16'd1; r.rd2 = pc + 16'd2;
    r.dst = dst; r.src_a = sa; r.use_a = ua; r.src_b = sb; r.use_b = ub;
    r.flush = fl; r.hold = hd;
    return r;
  endfunction

  // ID needs a value that the load in EX has not produced yet.
  function automatic logic needs_load(input slot_t m, input in_t i);
    logic reads_it;
    reads_it = (i.use_a && i.src_a == m.dst) || (i.use_b && i.src_b == m.dst);
    return i.valid && m.valid && m.ctrl.memread && m.ctrl.regwrite && reads_it;
  endfunction

  function automatic slot_t advance(input slot_t m, input in_t i);
    slot_t n = m;
    if (i.flush) begin
      n.valid = 1'b0; n.ctrl = '0;
    end else if (i.hold) begin
      n = m;
    end else if (needs_load(m, i)) begin
      n.valid = 1'b0; n.ctrl = '0;
      n.bubbles = (m.bubbles == 16'hFFFF) ? m.bubbles : m.bubbles + 16'd1;
    end else begin
      n.valid = i.valid;
      n.ctrl  = i.valid ? i.ctrl : '0;
      n.pc = i.pc; n.ir = i.ir; n.rd1 = i.rd1; n.rd2 = i.rd2; n.dst = i.dst;
    end
    return n;
  endfunction

  task automatic drive(input in_t i);
    valid_id = i.valid; ctrl_id = i.ctrl; pc_id = i.pc; ir_id = i.ir;
    rd1_id = i.rd1; rd2_id = i.rd2; src_a_id = i.src_a; src_b_id = i.src_b;
    use_a_id = i.use_a; use_b_id = i.use_b; dst_id = i.dst;
    flush_ex = i.flush; hold_ex = i.hold;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid_ex"}, 32'(valid_ex), 32'(model.valid));
    chk({tag, ".ctrl_ex"}, 32'(ctrl_ex), 32'(model.ctrl));
    chk({tag, ".pc_ex"}, 32'(pc_ex), 32'(model.pc));
    chk({tag, ".ir_ex"}, 32'(ir_ex), 32'(model.ir));
    chk({tag, ".rd1_ex"}, 32'(rd1_ex), 32'(model.rd1));
    chk({tag, ".rd2_ex"}, 32'(rd2_ex), 32'(model.rd2));
    chk({tag, ".dst_ex"}, 32'(dst_ex), 32'(model.dst));
    chk({tag, ".bubble_cnt"}, 32'(bubble_cnt), 32'(model.bubbles));
  endtask

  // One cycle: drive at negedge, check stall before the edge, check state after it.
  task automatic step(input in_t i, input string tag);
    @(negedge clk);
    drive(i);
    #1;
    chk({tag, ".stall_id"}, 32'(stall_id), 32'((needs_load(model, i) || i.hold) && !i.flush));
    model = advance(model, i);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  vec_t vt[12];
  in_t  ri;

  initial begin
    model = '0;
    drive(mk(1'b0, 16'h0, 16'h0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    chk("reset.stall_id", 32'(stall_id), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    //            valid ctrl  pc       dst   sa   ua   sb   ub   fl   hd         stall valid ctrl pc      bcnt
    vt[0]  = '{mk(1, LW,  16'h0100, 3'd1, 3'd2, 1, 3'd3, 0, 0, 0), 0, 1, ctrl_t'(LW),  16'h0100, 16'd0};
    vt[1]  = '{mk(1, ADD, 16'h0102, 3'd3, 3'd1, 1, 3'd4, 1, 0, 0), 1, 0, ctrl_t'(0),   16'h0100, 16'd1};
    vt[2]  = '{mk(1, ADD, 16'h0102, 3'd3, 3'd1, 1, 3'd4, 1, 0, 0), 0, 1, ctrl_t'(ADD), 16'h0102, 16'd1};
    vt[3]  = '{mk(1, LW,  16'h0104, 3'd1, 3'd2, 1, 3'd0, 0, 0, 0), 0, 1, ctrl_t'(LW),  16'h0104, 16'd1};
    vt[4]  = '{mk(1, ADD, 16'h0106, 3'd3, 3'd1, 1, 3'd4, 1, 1, 0), 0, 0, ctrl_t'(0),   16'h0104, 16'd1};
    vt[5]  = '{mk(1, LW,  16'h0108, 3'd1, 3'd2, 1, 3'd0, 0, 0, 0), 0, 1, ctrl_t'(LW),  16'h0108, 16'd1};
    vt[6]  = '{mk(1, ADD, 16'h010A, 3'd3, 3'd1, 0, 3'd5, 1, 0, 0), 0, 1, ctrl_t'(ADD), 16'h010A, 16'd1};
    vt[7]  = '{mk(1, ADI, 16'h010C, 3'd2, 3'd3, 1, 3'd0, 0, 0, 0), 0, 1, ctrl_t'(ADI), 16'h010C, 16'd1};
    vt[8]  = '{mk(1, ADD, 16'h010E, 3'd4, 3'd2, 1, 3'd2, 1, 0, 1), 1, 1, ctrl_t'(ADI), 16'h010C, 16'd1};
    vt[9]  = '{mk(1, LW,  16'h0200, 3'd5, 3'd6, 1, 3'd2, 1, 0, 1), 1, 1, ctrl_t'(ADI), 16'h010C, 16'd1};
    vt[10] = '{mk(0, ADD, 16'h0300, 3'd6, 3'd7, 1, 3'd2, 1, 0, 1), 1, 1, ctrl_t'(ADI), 16'h010C, 16'd1};
    vt[11] = '{mk(0, ADD, 16'h0110, 3'd6, 3'd2, 1, 3'd2, 1, 0, 0), 0, 0, ctrl_t'(0),   16'h0110, 16'd1};

    for (int k = 0; k < 12; k++) begin
      step(vt[k].in, $sformatf("vec%0d", k));
      chk($sformatf("vec%0d.tbl_valid", k), 32'(valid_ex), 32'(vt[k].exp_valid));
      chk($sformatf("vec%0d.tbl_ctrl", k), 32'(ctrl_ex), 32'(vt[k].exp_ctrl));
      chk($sformatf("vec%0d.tbl_pc", k), 32'(pc_ex), 32'(vt[k].exp_pc));
      chk($sformatf("vec%0d.tbl_bcnt", k), 32'(bubble_cnt), 32'(vt[k].exp_bcnt));
    end

    // Counter saturation: preset to 0xFFFE, then three load-use events.
    @(negedge clk);
    force dut.bubble_cnt_q = 16'hFFFE;
    #1;
    release dut.bubble_cnt_q;
    model.bubbles = 16'hFFFE;
    for (int k = 0; k < 3; k++) begin
      step(mk(1, LW,  16'h0400, 3'd1, 3'd2, 1, 3'd0, 0, 0, 0), $sformatf("sat_lw%0d", k));
      step(mk(1, ADD, 16'h0402, 3'd3, 3'd0, 0, 3'd1, 1, 0, 0), $sformatf("sat_add%0d", k));
      chk($sformatf("sat%0d.bcnt", k), 32'(bubble_cnt), 32'hFFFF);
    end

    // Async reset pulse while a load-use stall is pending.
    step(mk(1, LW, 16'h0500, 3'd1, 3'd2, 1, 3'd0, 0, 0, 0), "rst_lw");
    @(negedge clk);
    ri = mk(1, ADD, 16'h0010, 3'd3, 3'd1, 1, 3'd0, 0, 0, 0);
    drive(ri);
    #1;
    chk("rst.stall_before", 32'(stall_id), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    model = '0;
    check_outputs("rst_async");
    chk("rst.stall_during", 32'(stall_id), 32'd0);
    #1 reset_n = 1'b1;
    model = advance(model, ri);
    @(posedge clk);
    #1;
    check_outputs("rst_release");
    chk("rst.pc_capture", 32'(pc_ex), 32'h0010);
    chk("rst.valid_capture", 32'(valid_ex), 32'd1);

    // Randomized traffic with small register indices to provoke hazards.
    for (int k = 0; k < 400; k++) begin
      ri.valid = ($urandom_range(0, 7) != 0);
      ri.ctrl  = ctrl_t'(16'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        ri.ctrl.memread  = 1'b1;
        ri.ctrl.regwrite = 1'b1;
      end
      ri.pc    = 16'($urandom);
      ri.ir    = 16'($urandom);
      ri.rd1   = 16'($urandom);
      ri.rd2   = 16'($urandom);
      ri.src_a = 3'($urandom_range(0, 3));
      ri.src_b = 3'($urandom_range(0, 3));
      ri.dst   = 3'($urandom_range(0, 3));
      ri.use_a = 1'($urandom);
      ri.use_b = 1'($urandom);
      ri.flush = ($urandom_range(0, 7) == 0);
      ri.hold  = ($urandom_range(0, 5) == 0);
      step(ri, $sformatf("rnd%0d", k));
      chk($sformatf("rnd%0d.bubble_no_side_effect", k),
          32'(!valid_ex && (ctrl_ex.regwrite || ctrl_ex.memwrite || ctrl_ex.memread)), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 SHALL provide: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL provide: reset_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL provide: ctrl_id  input  16  packed decode-control bundle from the ID-stage controller (regwrite, memtoreg, memread, memwrite, branch, regdest, pc_regread, lhi_reg, alusrc[1:0], irlast[1:0], aluop[3:0]).
REQ-004 SHALL provide: valid_id  input  1  ID slot holds a real instruction.
REQ-005 SHALL provide: pc_id  input  16  PC of the ID instruction.
REQ-006 SHALL provide: ir_id  input  16  instruction word.
REQ-007 SHALL provide: rd1_id  input  16  register-file read data A.
REQ-008 SHALL provide: rd2_id  input  16  register-file read data B.
REQ-009 SHALL provide: src_a_id, src_b_id  input  3 each  source register indices.
REQ-010 SHALL provide: use_a_id, use_b_id  input  1 each  source actually read.
REQ-011 SHALL provide: dst_id  input  3  destination register index.
REQ-012 SHALL provide: flush_ex  input  1  branch/jump resolved taken; kill the instruction entering EX.
REQ-013 SHALL provide: hold_ex  input  1  downstream stall; freeze EX.
REQ-014 SHALL provide: ctrl_ex, pc_ex, ir_ex, rd1_ex, rd2_ex  output  16 each  registered copies.
REQ-015 SHALL provide: dst_ex  output  3; valid_ex  output  1.
REQ-016 SHALL provide: stall_id  output  1  freeze PC and IF/ID (combinational).
REQ-017 SHALL provide: bubble_cnt  output  16  count of load-use bubbles inserted.

Function
REQ-018 Latency SHALL be one cycle, ID to EX.
REQ-019 load_use SHALL be valid_id & valid_ex & ctrl_ex.memread & ctrl_ex.regwrite & ((use_a_id & src_a_id==dst_ex) | (use_b_id & src_b_id==dst_ex)).
REQ-020 stall_id SHALL equal (load_use | hold_ex) & ~flush_ex.
REQ-021 Per-edge priority SHALL be flush_ex > hold_ex > load_use > normal capture.
REQ-022 On flush_ex, next state SHALL be valid_ex=0 and ctrl_ex=0; data outputs hold their values; bubble_cnt is unchanged.
REQ-023 On hold_ex without flush_ex, all registers including bubble_cnt SHALL retain their values.
REQ-024 On load_use, next state SHALL be valid_ex=0 and ctrl_ex=0 (bubble), data outputs hold their values, and bubble_cnt increments by 1, saturating at 0xFFFF.
REQ-025 On normal capture, all *_id inputs SHALL load into the *_ex registers and valid_ex<=valid_id; if valid_id=0, ctrl_ex SHALL load 0.
REQ-026 A bubble SHALL never carry regwrite, memwrite or memread, so no architectural side effect.
REQ-027 Consecutive load-use on the same load SHALL insert exactly one bubble: after the bubble, valid_ex=0 so load_use clears.

Reset
REQ-028 While reset_n=0, every output register SHALL be 0, including valid_ex, ctrl_ex and bubble_cnt; stall_id=0 follows.
REQ-029 Reset assertion mid-stall SHALL discard the pending bubble; the first edge after release performs a normal capture.

Structure
REQ-030 The ctrl bundle typedef, its field offsets and the register-index width (3) SHALL live in the shared processor package, reused by the controller.
REQ-031 Hazard compare SHALL be the single sub-module lu_hazard_detect; the register and counter logic stays in this module.

Verification
REQ-032 LW r1 in EX, ADD using r1 in ID, valid -> stall_id=1, next cycle valid_ex=0, ctrl_ex=0, bubble_cnt 0->1, ADD enters EX one cycle later.
REQ-033 Same as REQ-032 with flush_ex=1 -> stall_id=0, valid_ex=0, bubble_cnt unchanged.
REQ-034 hold_ex=1 for 3 cycles with ADI in EX -> ctrl_ex, pc_ex, ir_ex unchanged and stall_id=1 throughout.
REQ-035 bubble_cnt preset to 0xFFFE, then 3 load-use events -> 0xFFFF and stays there.
REQ-036 reset_n pulsed low asynchronously mid-cycle during stall -> outputs immediately 0; after release, pc_id=0x0010 is captured on the next edge.
REQ-037 LW r1 in EX, ADD with use_a_id=0 and src_a_id=1 -> no stall, normal capture.
